// File: rtl/bicubic_lb_pkg.sv
// Shared constants and types for the bicubic line-buffer bank.
package bicubic_lb_pkg;

    localparam int LB_ADDR_W        = 11;
    localparam int LB_DATA_W        = 8;
    localparam int LB_NUM_ROWS      = 4;
    localparam int LB_IMG_W_DEFAULT = 1920;

    typedef logic [1:0] lb_row_idx_t;

    function automatic logic [LB_NUM_ROWS-1:0] row_onehot(input lb_row_idx_t row);
        return 4'b0001 << row;
    endfunction

endpackage

// File: rtl/bicubic_line_writer.sv
// Write-side controller for the bicubic line-buffer bank: rotates raster lines
// across four rows and back-pressures the stream when every row is occupied.
module bicubic_line_writer
    import bicubic_lb_pkg::*;
#(
    parameter int IMG_W  = LB_IMG_W_DEFAULT,
    parameter int ADDR_W = LB_ADDR_W,
    parameter int DATA_W = LB_DATA_W
) (
    input  logic              clk_in1,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              line_release,
    output logic              bram0_wenb,
    output logic              bram1_wenb,
    output logic              bram2_wenb,
    output logic              bram3_wenb,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              line_done,
    output logic [1:0]        done_bank,
    output logic [2:0]        fill_cnt,
    output logic              release_err
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [2:0]        FULL     = 3'(LB_NUM_ROWS);

    logic [ADDR_W-1:0]      col;
    lb_row_idx_t            wr_bank;
    logic [LB_NUM_ROWS-1:0] wenb;

    logic              accept;
    logic              sof_beat;
    logic              line_end;
    logic              rel_ok;
    lb_row_idx_t       tgt_bank;
    logic [ADDR_W-1:0] tgt_col;

    assign s_ready  = (fill_cnt != FULL);
    assign accept   = s_valid & s_ready;
    assign sof_beat = accept & s_sof;

    // A start-of-frame beat lands at row 0, column 0 regardless of the current position.
    assign tgt_bank = sof_beat ? lb_row_idx_t'(0) : wr_bank;
    assign tgt_col  = sof_beat ? '0 : col;
    assign line_end = accept && (tgt_col == LAST_COL);
    assign rel_ok   = line_release && !sof_beat && (fill_cnt != 3'd0);

    assign bram0_wenb = wenb[0];
    assign bram1_wenb = wenb[1];
    assign bram2_wenb = wenb[2];
    assign bram3_wenb = wenb[3];

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_in1) begin
        if (rst) begin
            col         <= '0;
            wr_bank     <= '0;
            fill_cnt    <= '0;
            wenb        <= '0;
            bram_waddr  <= '0;
            bram_wdata  <= '0;
            line_done   <= 1'b0;
            done_bank   <= '0;
            release_err <= 1'b0;
        end else begin
            wenb      <= '0;
            line_done <= 1'b0;

            if (accept) begin
                wenb       <= row_onehot(tgt_bank);
                bram_waddr <= tgt_col;
                bram_wdata <= s_data;
                if (line_end) begin
                    col       <= '0;
                    wr_bank   <= tgt_bank + 2'd1;
                    line_done <= 1'b1;
                    done_bank <= tgt_bank;
                end else begin
                    col     <= tgt_col + 1'b1;
                    wr_bank <= tgt_bank;
                end
            end

            // Simultaneous completion and release cancel out.
            if (sof_beat) begin
                fill_cnt <= 3'(line_end);
            end else begin
                fill_cnt <= fill_cnt + 3'(line_end) - 3'(rel_ok);
            end

            if (line_release && !sof_beat && (fill_cnt == 3'd0)) begin
                release_err <= 1'b1;
            end
        end
    end

endmodule
